// File: rtl/delays_array_prog.sv
// delays_array_prog: per-channel programmable tapped delay lines.
// Each channel writes into a circular buffer. Tap k of channel i reads the
// sample that is base[i] + k*spacing samples old. Taps that would reach past
// the samples written since reset or the last accepted config read as zero.
module delays_array_prog #(
  parameter int NIN         = 8,
  parameter int IN_WIDTH    = 14,
  parameter int NT          = 4,
  parameter int MAX_BASE    = 15,
  parameter int MAX_SPACING = 4,
  localparam int BW    = $clog2(MAX_BASE + 1),
  localparam int SW    = $clog2(MAX_SPACING + 1),
  localparam int DEPTH = MAX_BASE + (NT - 1) * MAX_SPACING + 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ena,
  input  logic [NIN*IN_WIDTH-1:0]    data_in,
  input  logic                       cfg_load,
  input  logic [NIN*BW-1:0]          cfg_base,
  input  logic [SW-1:0]              cfg_spacing,
  output logic                       cfg_err,
  output logic [NIN*NT*IN_WIDTH-1:0] data_dly,
  output logic                       dly_valid
);

  localparam int AW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  logic [IN_WIDTH-1:0] mem [NIN][DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] fill_cnt;
  logic [AW-1:0] max_off;
  logic [BW-1:0] act_base [NIN];
  logic [SW-1:0] act_spacing;

  logic                       cfg_ok;
  logic                       cfg_take;
  logic [BW-1:0]              eff_base [NIN];
  logic [SW-1:0]              eff_spacing;
  logic [BW-1:0]              new_max_base;
  logic [AW-1:0]              new_max_off;
  logic [AW-1:0]              fill_new;
  logic [AW-1:0]              off_v;
  logic [AW-1:0]              rd_v;
  logic [NIN*NT*IN_WIDTH-1:0] dly_next;

  // Validate the offered config and pick the config that governs this edge.
  always_comb begin
    cfg_ok = (cfg_spacing != '0) && ({1'b0, cfg_spacing} <= (SW+1)'(MAX_SPACING));
    new_max_base = '0;
    for (int i = 0; i < NIN; i++) begin
      if ({1'b0, cfg_base[i*BW +: BW]} > (BW+1)'(MAX_BASE)) cfg_ok = 1'b0;
      if (cfg_base[i*BW +: BW] > new_max_base) new_max_base = cfg_base[i*BW +: BW];
    end
    cfg_take = cfg_load && cfg_ok;
    new_max_off = AW'(new_max_base) + AW'(NT - 1) * AW'(cfg_spacing);
    for (int i = 0; i < NIN; i++) begin
      eff_base[i] = cfg_take ? cfg_base[i*BW +: BW] : act_base[i];
    end
    eff_spacing = cfg_take ? cfg_spacing : act_spacing;
  end

  // Next fill count and masked tap values; offset 0 bypasses the buffer.
  always_comb begin
    if (cfg_take) begin
      fill_new = ena ? AW'(1) : '0;
    end else if (ena && (fill_cnt != DEPTH_A)) begin
      fill_new = fill_cnt + AW'(1);
    end else begin
      fill_new = fill_cnt;
    end
    dly_next = '0;
    off_v    = '0;
    rd_v     = '0;
    for (int i = 0; i < NIN; i++) begin
      for (int k = 0; k < NT; k++) begin
        off_v = AW'(eff_base[i]) + AW'(k) * AW'(eff_spacing);
        rd_v  = (wr_ptr >= off_v) ? (wr_ptr - off_v) : (wr_ptr + DEPTH_A - off_v);
        if (off_v < fill_new) begin
          dly_next[(i*NT+k)*IN_WIDTH +: IN_WIDTH] =
            (off_v == '0) ? data_in[i*IN_WIDTH +: IN_WIDTH] : mem[i][rd_v[PW-1:0]];
        end
      end
    end
  end

  // Sample buffers are never cleared; stale contents are hidden by fill masking.
  always_ff @(posedge clk) begin
    if (resetn && ena) begin
      for (int i = 0; i < NIN; i++) begin
        mem[i][wr_ptr[PW-1:0]] <= data_in[i*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  // Pointer, fill, active config and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      data_dly    <= '0;
      dly_valid   <= 1'b0;
      cfg_err     <= 1'b0;
      for (int i = 0; i < NIN; i++) begin
        act_base[i] <= '0;
      end
      act_spacing <= SW'(1);
      max_off     <= AW'(NT - 1);
    end else begin
      if (cfg_load) cfg_err <= ~cfg_ok;
      if (cfg_take) begin
        for (int i = 0; i < NIN; i++) begin
          act_base[i] <= cfg_base[i*BW +: BW];
        end
        act_spacing <= cfg_spacing;
        max_off     <= new_max_off;
      end
      fill_cnt <= fill_new;
      if (ena) begin
        wr_ptr    <= (wr_ptr == LAST_A) ? '0 : wr_ptr + AW'(1);
        data_dly  <= dly_next;
        dly_valid <= ~cfg_take && (fill_new > max_off);
      end else if (cfg_take) begin
        dly_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_delays_array_prog.sv
// Scoreboard bench for delays_array_prog: the driver pushes the expected
// outputs for each clock edge, a monitor pops and compares after the edge.
module tb_delays_array_prog;

  localparam int NIN = 8;
  localparam int IW  = 14;
  localparam int NT  = 4;
  localparam int BW  = 4;
  localparam int SW  = 3;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               ena = 1'b0;
  logic               cfg_load = 1'b0;
  logic [NIN*IW-1:0]  data_in = '0;
  logic [NIN*BW-1:0]  cfg_base = '0;
  logic [SW-1:0]      cfg_spacing = 3'd1;
  logic               cfg_err;
  logic               dly_valid;
  logic [NIN*NT*IW-1:0] data_dly;

  typedef struct {
    logic [NIN*NT*IW-1:0] dly;
    logic                 valid;
    logic                 err;
    logic                 spot_en;
    int                   spot_ch;
    int                   spot_tap;
    logic [IW-1:0]        spot_val;
  } exp_t;

  exp_t sbq[$];

  logic [NIN*IW-1:0]    hist[$];
  int                   mbase [NIN];
  int                   msp = 1;
  logic                 merr = 1'b0;
  int                   mfill = 0;
  logic [NIN*NT*IW-1:0] mdly = '0;
  logic                 mvalid = 1'b0;

  int rn = 0;
  int spot_ch = 0;
  int spot_tap = 0;
  int spot_off = -1;
  int nvec = 0;
  int nfail = 0;

  delays_array_prog dut (
    .clk(clk),
    .resetn(resetn),
    .ena(ena),
    .data_in(data_in),
    .cfg_load(cfg_load),
    .cfg_base(cfg_base),
    .cfg_spacing(cfg_spacing),
    .cfg_err(cfg_err),
    .data_dly(data_dly),
    .dly_valid(dly_valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of ramp stimulus, update the sample-history model and
  // queue the expected outputs once the edge has happened.
  task automatic applyStimulus(input logic rstn, input logic en, input logic load);
    exp_t e;
    bit ok;
    int mo;
    int off;
    logic [NIN*IW-1:0] h;
    #1;
    resetn   = rstn;
    ena      = en;
    cfg_load = load;
    for (int i = 0; i < NIN; i++) data_in[i*IW +: IW] = IW'(i * rn);
    e.spot_en = 1'b0; e.spot_ch = 0; e.spot_tap = 0; e.spot_val = '0;
    if (!rstn) begin
      for (int i = 0; i < NIN; i++) mbase[i] = 0;
      msp = 1; merr = 1'b0; mfill = 0; mdly = '0; mvalid = 1'b0;
      hist.delete();
      rn = 0;
    end else begin
      ok = 1'b0;
      if (load) begin
        ok = (int'(cfg_spacing) >= 1) && (int'(cfg_spacing) <= 4);
        for (int i = 0; i < NIN; i++) if (int'(cfg_base[i*BW +: BW]) > 15) ok = 1'b0;
        merr = !ok;
        if (ok) begin
          for (int i = 0; i < NIN; i++) mbase[i] = int'(cfg_base[i*BW +: BW]);
          msp = int'(cfg_spacing);
          mfill = 0;
          mvalid = 1'b0;
        end
      end
      if (en) begin
        hist.push_back(data_in);
        if (hist.size() > 40) void'(hist.pop_front());
        mfill++;
        mo = 0;
        for (int i = 0; i < NIN; i++) if (mbase[i] + (NT-1)*msp > mo) mo = mbase[i] + (NT-1)*msp;
        for (int i = 0; i < NIN; i++) begin
          for (int k = 0; k < NT; k++) begin
            off = mbase[i] + k*msp;
            if (off < mfill) begin
              h = hist[hist.size()-1-off];
              mdly[(i*NT+k)*IW +: IW] = h[i*IW +: IW];
            end else begin
              mdly[(i*NT+k)*IW +: IW] = '0;
            end
          end
        end
        mvalid = !ok && (mfill > mo);
        if (spot_off >= 0) begin
          e.spot_en  = 1'b1;
          e.spot_ch  = spot_ch;
          e.spot_tap = spot_tap;
          e.spot_val = (mfill > spot_off) ? IW'(spot_ch * (rn - spot_off)) : '0;
        end
        rn++;
      end
    end
    e.dly = mdly; e.valid = mvalid; e.err = merr;
    @(posedge clk);
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [NIN*NT*IW-1:0] got,
                             input logic [NIN*NT*IW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("[TB] FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("[TB] FAIL %s t=%0t got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Monitor: after every edge that has a queued expectation, compare outputs.
  initial begin : monitor
    exp_t e;
    logic [IW-1:0] got;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("data_dly", data_dly, e.dly);
        checkFlag("dly_valid", dly_valid, e.valid);
        checkFlag("cfg_err", cfg_err, e.err);
        if (e.spot_en) begin
          got = data_dly[(e.spot_ch*NT + e.spot_tap)*IW +: IW];
          nvec++;
          if (got !== e.spot_val) begin
            nfail++;
            $display("[TB] FAIL spot ch%0d tap%0d t=%0t got %0d expected %0d",
                     e.spot_ch, e.spot_tap, $time, got, e.spot_val);
          end
        end
      end
    end
  end

  // Directed scenarios: defaults, programmed base/spacing, ena gaps,
  // rejected loads, maximum offset across pointer wraps, mid-stream reset.
  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    spot_ch = 3;
    for (int n = 0; n < 10; n++) begin
      spot_tap = n % 4; spot_off = n % 4;
      applyStimulus(1'b1, 1'b1, 1'b0);
    end

    spot_off = -1;
    cfg_base = '0; cfg_base[2*BW +: BW] = 4'd5; cfg_spacing = 3'd3;
    applyStimulus(1'b1, 1'b0, 1'b1);
    spot_ch = 2; spot_tap = 3; spot_off = 14;
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0);
    spot_tap = 0; spot_off = 5;
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);

    spot_tap = 3; spot_off = 14;
    repeat (3) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
    end

    cfg_spacing = 3'd0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    cfg_spacing = 3'd5;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);

    cfg_base = '0; cfg_base[7*BW +: BW] = 4'd15; cfg_spacing = 3'd4;
    spot_ch = 7; spot_tap = 3; spot_off = 27;
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (90) applyStimulus(1'b1, 1'b1, 1'b0);

    spot_off = -1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    spot_ch = 3;
    for (int n = 0; n < 10; n++) begin
      spot_tap = n % 4; spot_off = n % 4;
      applyStimulus(1'b1, 1'b1, 1'b0);
    end

    #1;
    ena = 1'b0; cfg_load = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      nvec++; nfail++;
      $display("[TB] FAIL scoreboard_drain left %0d expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/delays_array_prog.md
Name: delays_array_prog

Overview:
Programmable successor to delays_array for the CRPA space-time front end.
- Each of NIN ADC channels feeds an NT-tap delay line.
- Per-channel base delay and a global tap spacing are runtime-programmable.
- Tap outputs feed the STAP weight/combiner stage.
- Adds fill tracking with a valid flag, zeroing of not-yet-filled taps, and configuration validation.

Parameters:
NIN, 8, number of input channels
IN_WIDTH, 14, sample width (two's complement, passed through unmodified)
NT, 4, taps per channel
MAX_BASE, 15, maximum per-channel base delay in samples
MAX_SPACING, 4, maximum tap spacing in samples
Derived: BW = clog2(MAX_BASE+1); SW = clog2(MAX_SPACING+1); DEPTH = MAX_BASE + (NT-1)*MAX_SPACING + 1 (28 at defaults); MAXOFF = DEPTH-1.

Ports:
clk  in  1  single clock
resetn  in  1  reset, synchronous, active-low
ena  in  1  sample strobe; one input sample per channel per cycle with ena=1
data_in  in  NIN*IN_WIDTH  channel i at bits [i*IN_WIDTH +: IN_WIDTH]
cfg_load  in  1  single-cycle strobe to apply cfg_base/cfg_spacing
cfg_base  in  NIN*BW  per-channel base delay, channel i at [i*BW +: BW]
cfg_spacing  in  SW  tap spacing for all channels
cfg_err  out  1  sticky: last cfg_load was rejected
data_dly  out  NIN*NT*IN_WIDTH  channel i, tap k at [(i*NT+k)*IN_WIDTH +: IN_WIDTH]
dly_valid  out  1  every tap of every channel references a sample written since the last reset or applied config

Behaviour:
- Reset (resetn=0 at a clk edge):
  - wr_ptr=0, fill_cnt=0, data_dly=0, dly_valid=0, cfg_err=0.
  - Active base[i]=0, active spacing=1, which gives classic consecutive-sample taps.
  - Buffer contents are not cleared; zeroing is done by fill masking.
- Tap offset: off(i,k) = base[i] + k*spacing, range 0..MAXOFF.
- Write path, on an edge with ena=1:
  - Write data_in[i] into channel-i circular buffer at wr_ptr.
  - wr_ptr increments, wrapping DEPTH-1 -> 0.
  - fill_cnt increments, saturating at DEPTH.
- Output path, same edge, registered, latency 1:
  - Let x_i[n] be the sample accepted on this edge.
  - data_dly(i,k) <= x_i[n - off(i,k)] if off(i,k) < fill_cnt_new, else 0.
  - fill_cnt_new counts the current sample.
  - off=0 bypasses to data_in directly. There is no read-during-write hazard.
- dly_valid <= (fill_cnt_new > max over i of off(i,NT-1)); registered alongside data_dly.
- ena=0: buffers, wr_ptr, fill_cnt, data_dly and dly_valid all hold.
- cfg_load=1 validation:
  - Reject if cfg_spacing==0, cfg_spacing>MAX_SPACING, or any cfg_base[i]>MAX_BASE.
  - On reject: cfg_err<=1 and the active config, fill_cnt and outputs are unaffected.
  - On accept: cfg_err<=0, active config updated, fill_cnt<=(ena?1:0), dly_valid<=0.
  - Newly applied config governs any data_dly update on the same edge. Taps needing older samples output 0.
- The per-edge max-offset comparison uses the active config. A precomputed registered max offset is recomputed only on accepted cfg_load.
- Reset has priority over cfg_load and ena. Reset mid-stream immediately zeroes outputs and restores the default config.
- Arithmetic: offset and pointer math are modulo DEPTH. The read address (wr_ptr - off) wraps correctly for every off <= MAXOFF.

Test Plan:
1. Defaults after reset; channel i input ramp x_i[n]=i*n (data_in[i] += i each cycle, ena=1).
   -> ch3 tap k = 3*(n-k).
   -> Taps 1..3 are zero until filled.
   -> dly_valid rises on the output update for the 4th accepted sample.
2. cfg_load with base[2]=5, base[0]=0, others 0, spacing=3.
   -> ch2 offsets 5,8,11,14; ch0 offsets 0,3,6,9.
   -> dly_valid=0 for 14 accepted samples, 1 from the 15th.
   -> ch2 tap3 = 2*(n-14).
3. ena toggling 1,0,0,1 during the ramp.
   -> Outputs and dly_valid hold during ena=0.
   -> The next accepted sample continues the sequence with no skipped or duplicated offsets.
4. cfg_load with spacing=0, then spacing=5.
   -> cfg_err=1 one cycle after each load; config and dly_valid unchanged.
   -> A following valid load clears cfg_err.
5. base[7]=15, spacing=4 (offset 27 = MAXOFF), run more than 3*DEPTH samples.
   -> ch7 tap3 = 7*(n-27) across every pointer wrap.
   -> dly_valid rises after the 28th sample.
6. resetn=0 for one cycle mid-stream with non-default config.
   -> Next cycle data_dly=0, dly_valid=0, cfg_err=0, spacing=1, all bases 0.
   -> Refill behaves exactly as scenario 1.
